ofdm_frame_assembler: RTL and testbench
=======================================

# ofdm_frame_assembler

Builds each transmit OFDM frame in the frequency domain, immediately downstream of the sync-word loader. On each frame it snapshots the loaded sync word and BPSK-maps it onto the used subcarriers of one FFT-sized symbol. It then passes NUM_DATA_SYMBOLS data symbols through from the upstream data path. The result is a single AXI-Stream of complex bins in natural FFT order, feeding the IFFT.

## Interface
- FFT_SIZE, 1024, bins per symbol; power of two, 16 to 4096
- USED_CARRIERS, 800, sync-word width and number of loaded carriers; even, less than FFT_SIZE
- NUM_DATA_SYMBOLS, 10, data symbols per frame; 1 to 255
- SYNC_AMPLITUDE, 16'h4000, BPSK magnitude in Q1.15

Ports:
- s_axis_aclk  in  1  sole clock
- s_axis_aresetn  in  1  synchronous reset, active-low
- enable  in  1  permits a new frame to start
- sync_word  in  USED_CARRIERS  sync pattern from the loader
- sync_word_valid  in  1  loader has received the full word
- s_axis_data_tdata  in  32  data bin {Q[31:16], I[15:0]}, signed Q1.15
- s_axis_data_tvalid  in  1
- s_axis_data_tready  out  1
- s_axis_data_tlast  in  1  expected on bin FFT_SIZE-1 of each data symbol
- m_axis_tdata  out  32  output bin {Q, I}
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  last bin of every symbol
- m_axis_tuser  out  1  1 on every sync-symbol bin
- busy  out  1  state is not IDLE
- framing_error  out  1  sticky; set on tlast mismatch
- frames_sent  out  32  completed-frame counter; wraps modulo 2^32

## Operation
- States: IDLE, SYNC, DATA.
- Counters:
  - bin counter is $clog2(FFT_SIZE) bits
  - symbol counter is $clog2(NUM_DATA_SYMBOLS+1) bits
- IDLE → SYNC:
  - Taken when enable && sync_word_valid at a clock edge.
  - On that edge: sync_word latches into an internal snapshot, bin=0, sym=0.
  - Later changes to sync_word do not affect the frame in flight.
- SYNC mapping, with H = USED_CARRIERS/2, for bin k:
  - k=0 (DC): 0
  - 1 ≤ k ≤ H: snapshot bit H+k-1
  - FFT_SIZE-H ≤ k ≤ FFT_SIZE-1: snapshot bit k-(FFT_SIZE-H)
  - all other bins (guards): 0
  - mapped bit 1 → I=+SYNC_AMPLITUDE; bit 0 → I=-SYNC_AMPLITUDE (two's complement); Q=0
- SYNC → DATA: after bin FFT_SIZE-1 is loaded into the output register.
- DATA:
  - Pass-through of s_axis_data bins into the output register.
  - s_axis_data_tready = (state==DATA) && (!m_axis_tvalid || m_axis_tready).
  - bin advances on each accepted beat.
  - When bin FFT_SIZE-1 is accepted, sym increments.
- End of frame: after bin FFT_SIZE-1 of symbol NUM_DATA_SYMBOLS-1 is accepted:
  - frames_sent increments.
  - Next state is SYNC if enable && sync_word_valid (new snapshot, no idle cycle); otherwise IDLE.
- enable deasserting mid-frame does not abort the frame; it only prevents the next one.
- Framing error: s_axis_data_tlast is sampled on each accepted data beat.
  - Mismatch with (bin==FFT_SIZE-1) sets framing_error.
  - Bin counting is unaffected (counting is authoritative).
  - framing_error clears only on reset.
- Output register:
  - Single stage; loads when (!m_axis_tvalid || m_axis_tready) and a source beat is available.
  - In SYNC the source is always available.
  - m_axis_tlast = 1 for bin FFT_SIZE-1.
  - m_axis_tuser = 1 in SYNC.

## Timing
- Reset values: state IDLE, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_data_tready=0, busy=0, framing_error=0, frames_sent=0, counters 0.
- Reset asserted mid-frame: the next edge returns to IDLE and drops m_axis_tvalid; the in-flight beat is discarded.
- IDLE→SYNC decided at edge N: busy=1 after N; first sync bin valid after edge N+1.
- Latency: one cycle from source beat to m_axis.
- Throughput: one bin per cycle, with no bubble between symbols or back-to-back frames, while m_axis_tready and s_axis_data_tvalid stay high.
- Backpressure (m_axis_tready=0): m_axis_tdata/tlast/tuser hold stable and no counter advances.
- Full frame = (1+NUM_DATA_SYMBOLS)·FFT_SIZE output beats.

## Test plan
Parameters for all scenarios: FFT_SIZE=16, USED_CARRIERS=8, NUM_DATA_SYMBOLS=2, SYNC_AMPLITUDE=16'h4000.

- **Sync mapping:** sync_word=8'b1010_0110, enable=1, m_axis_tready=1 → sync-symbol bins 0..15 are:
  - 0, C000, 4000, C000, 4000 (bins 0–4)
  - 0 × 7 (bins 5–11)
  - C000, 4000, 4000, C000 (bins 12–15)
  - tdata upper half 0; tuser=1 on all 16 bins; tlast on bin 15 only.
- **Data pass-through:** data tdata=0x00010000+index, correct tlast → 32 data beats appear unchanged with tuser=0, tlast on beats 15 and 31, then frames_sent=1; with enable=0 the block returns to IDLE and busy=0.
- **Backpressure:** toggle m_axis_tready pseudo-randomly → exactly 48 beats per frame, identical sequence, no duplicated or lost beats, outputs stable while stalled.
- **Snapshot:** change sync_word to all-ones during the data symbols with enable=1 → the current frame is unchanged; the next frame's sync bins are 4000 on bins 1–4 and 12–15, with no gap beat between frames.
- **Framing error:** assert s_axis_data_tlast on data bin 7 → framing_error=1 and stays set; the frame still completes with 48 beats.
- **Reset mid-frame:** drive s_axis_aresetn=0 for one cycle at sync bin 5 → next cycle m_axis_tvalid=0, busy=0, frames_sent=0; the following frame starts cleanly at bin 0.

Source files
------------

// File: rtl/ofdm_frame_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ofdm_frame_assembler                                         |
// | Description : Emits one BPSK sync symbol built from a snapshotted sync     |
// |               word, then passes NUM_DATA_SYMBOLS data symbols to the IFFT. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ofdm_frame_assembler #(
    parameter int          FFT_SIZE         = 1024,
    parameter int          USED_CARRIERS    = 800,
    parameter int          NUM_DATA_SYMBOLS = 10,
    parameter logic [15:0] SYNC_AMPLITUDE   = 16'h4000
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    input  logic                     enable,
    input  logic [USED_CARRIERS-1:0] sync_word,
    input  logic                     sync_word_valid,
    input  logic [31:0]              s_axis_data_tdata,
    input  logic                     s_axis_data_tvalid,
    output logic                     s_axis_data_tready,
    input  logic                     s_axis_data_tlast,
    output logic [31:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic                     busy,
    output logic                     framing_error,
    output logic [31:0]              frames_sent
);

    localparam int c_BW = $clog2(FFT_SIZE);
    localparam int c_SW = $clog2(NUM_DATA_SYMBOLS + 1);
    localparam int c_IW = $clog2(USED_CARRIERS);
    localparam int c_H  = USED_CARRIERS / 2;

    localparam logic [c_BW-1:0] c_BIN_LAST = c_BW'(FFT_SIZE - 1);
    localparam logic [c_SW-1:0] c_SYM_LAST = c_SW'(NUM_DATA_SYMBOLS - 1);
    localparam logic [15:0]     c_NEG_AMP  = 16'(~SYNC_AMPLITUDE + 16'd1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SYNC = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    logic [1:0]               r_state;
    logic [USED_CARRIERS-1:0] r_snapshot;
    logic [c_BW-1:0]          r_bin;
    logic [c_SW-1:0]          r_sym;
    logic [31:0]              r_tdata;
    logic                     r_tvalid;
    logic                     r_tlast;
    logic                     r_tuser;
    logic                     r_framing_error;
    logic [31:0]              r_frames_sent;

    logic            w_out_ready;
    logic            w_start;
    logic            w_bin_last;
    logic            w_sync_used;
    logic [c_IW-1:0] w_idx;
    logic [15:0]     w_sync_i;

    assign w_out_ready = !r_tvalid || m_axis_tready;
    assign w_start     = enable && sync_word_valid;
    assign w_bin_last  = (r_bin == c_BIN_LAST);

    // Upper half of the word goes to positive carriers 1..H, lower half to the negative ones.
    always_comb begin
        w_sync_used = 1'b0;
        w_idx       = '0;
        if (r_bin != '0 && int'(r_bin) <= c_H) begin
            w_sync_used = 1'b1;
            w_idx       = c_IW'(c_H - 1 + int'(r_bin));
        end else if (int'(r_bin) >= FFT_SIZE - c_H) begin
            w_sync_used = 1'b1;
            w_idx       = c_IW'(int'(r_bin) - (FFT_SIZE - c_H));
        end
    end

    assign w_sync_i = !w_sync_used ? 16'h0000 :
                      (r_snapshot[w_idx] ? SYNC_AMPLITUDE : c_NEG_AMP);

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            r_state         <= c_IDLE;
            r_snapshot      <= '0;
            r_bin           <= '0;
            r_sym           <= '0;
            r_tdata         <= '0;
            r_tvalid        <= 1'b0;
            r_tlast         <= 1'b0;
            r_tuser         <= 1'b0;
            r_framing_error <= 1'b0;
            r_frames_sent   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_out_ready) r_tvalid <= 1'b0;
                    if (w_start) begin
                        r_snapshot <= sync_word;
                        r_bin      <= '0;
                        r_sym      <= '0;
                        r_state    <= c_SYNC;
                    end
                end
                c_SYNC: begin
                    if (w_out_ready) begin
                        r_tdata  <= {16'h0000, w_sync_i};
                        r_tvalid <= 1'b1;
                        r_tlast  <= w_bin_last;
                        r_tuser  <= 1'b1;
                        r_bin    <= r_bin + 1'b1;
                        if (w_bin_last) begin
                            r_bin   <= '0;
                            r_state <= c_DATA;
                        end
                    end
                end
                c_DATA: begin
                    if (w_out_ready) begin
                        if (s_axis_data_tvalid) begin
                            r_tdata  <= s_axis_data_tdata;
                            r_tvalid <= 1'b1;
                            r_tlast  <= w_bin_last;
                            r_tuser  <= 1'b0;
                            r_bin    <= r_bin + 1'b1;
                            // Upstream tlast is only audited; the bin counter stays authoritative.
                            if (s_axis_data_tlast != w_bin_last) r_framing_error <= 1'b1;
                            if (w_bin_last) begin
                                r_bin <= '0;
                                if (r_sym == c_SYM_LAST) begin
                                    r_sym         <= '0;
                                    r_frames_sent <= r_frames_sent + 32'd1;
                                    if (w_start) begin
                                        r_snapshot <= sync_word;
                                        r_state    <= c_SYNC;
                                    end else begin
                                        r_state    <= c_IDLE;
                                    end
                                end else begin
                                    r_sym <= r_sym + 1'b1;
                                end
                            end
                        end else begin
                            r_tvalid <= 1'b0;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign s_axis_data_tready = (r_state == c_DATA) && w_out_ready;
    assign m_axis_tdata       = r_tdata;
    assign m_axis_tvalid      = r_tvalid;
    assign m_axis_tlast       = r_tlast;
    assign m_axis_tuser       = r_tuser;
    assign busy               = (r_state != c_IDLE);
    assign framing_error      = r_framing_error;
    assign frames_sent        = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_frame_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ofdm_frame_assembler                                      |
// | Description : Directed bench for ofdm_frame_assembler (16-bin, 2 symbols). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ofdm_frame_assembler;

    localparam int c_FFT  = 16;
    localparam int c_USED = 8;
    localparam int c_NSYM = 2;
    localparam int c_BEATS = (1 + c_NSYM) * c_FFT;

    logic              s_axis_aclk = 1'b0;
    logic              s_axis_aresetn;
    logic              enable;
    logic [c_USED-1:0] sync_word;
    logic              sync_word_valid;
    logic [31:0]       s_axis_data_tdata;
    logic              s_axis_data_tvalid;
    logic              s_axis_data_tready;
    logic              s_axis_data_tlast;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              busy;
    logic              framing_error;
    logic [31:0]       frames_sent;

    ofdm_frame_assembler #(
        .FFT_SIZE         (c_FFT),
        .USED_CARRIERS    (c_USED),
        .NUM_DATA_SYMBOLS (c_NSYM),
        .SYNC_AMPLITUDE   (16'h4000)
    ) u_dut (
        .s_axis_aclk        (s_axis_aclk),
        .s_axis_aresetn     (s_axis_aresetn),
        .enable             (enable),
        .sync_word          (sync_word),
        .sync_word_valid    (sync_word_valid),
        .s_axis_data_tdata  (s_axis_data_tdata),
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .s_axis_data_tready (s_axis_data_tready),
        .s_axis_data_tlast  (s_axis_data_tlast),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tuser       (m_axis_tuser),
        .busy               (busy),
        .framing_error      (framing_error),
        .frames_sent        (frames_sent)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    logic        q_user[$];
    int          q_cyc[$];

    int tmode  = 0;   // 0: m_axis_tready held high, 1: random
    int err_en = 0;   // force a bogus tlast on data bin 7

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_sync(input logic [7:0] sw, input int k);
        logic b;
        if (k >= 1 && k <= 4)  b = sw[3 + k];
        else if (k >= 12)      b = sw[k - 12];
        else                   return 32'h0;
        return b ? 32'h0000_4000 : 32'h0000_C000;
    endfunction

    task automatic tick();
        @(posedge s_axis_aclk);
        #1;
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n = 0;
        while (q_data.size() < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_beats_seen"}, 64'(q_data.size() >= target), 64'd1);
    endtask

    task automatic start_frame();
        int n = 0;
        enable = 1'b1;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        enable = 1'b0;
    endtask

    task automatic check_frame(input string name, input int base, input logic [7:0] sw);
        logic [31:0] ed;
        for (int i = 0; i < c_BEATS; i++) begin
            if (base + i >= q_data.size()) begin
                check($sformatf("%s_missing%0d", name, i), 64'(q_data.size()), 64'(base + c_BEATS));
                return;
            end
            ed = (i < c_FFT) ? exp_sync(sw, i) : 32'h0001_0000 + 32'(i - c_FFT);
            check($sformatf("%s_data%0d", name, i), 64'(q_data[base+i]), 64'(ed));
            check($sformatf("%s_last%0d", name, i), 64'(q_last[base+i]), 64'((i % c_FFT) == c_FFT - 1));
            check($sformatf("%s_user%0d", name, i), 64'(q_user[base+i]), 64'(i < c_FFT));
        end
    endtask

    // Upstream source, sink backpressure and output monitor.
    initial begin
        int          didx = 0;
        int          cyc  = 0;
        logic        hs;
        logic        prev_stall = 1'b0;
        logic [33:0] held = '0;
        s_axis_data_tvalid = 1'b1;
        s_axis_data_tdata  = 32'h0001_0000;
        s_axis_data_tlast  = 1'b0;
        m_axis_tready      = 1'b1;
        forever begin
            @(negedge s_axis_aclk);
            hs = s_axis_data_tvalid && s_axis_data_tready;
            if (prev_stall)
                check("stall_hold", {29'd0, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                      {29'd0, 1'b1, held});
            if (m_axis_tvalid && m_axis_tready) begin
                q_data.push_back(m_axis_tdata);
                q_last.push_back(m_axis_tlast);
                q_user.push_back(m_axis_tuser);
                q_cyc.push_back(cyc);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready && s_axis_aresetn;
            held       = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            @(posedge s_axis_aclk);
            #1;
            cyc++;
            if (hs) didx++;
            s_axis_data_tdata = 32'h0001_0000 + 32'(didx % 32);
            s_axis_data_tlast = ((didx % 16) == 15) || (err_en != 0 && (didx % 32) == 7);
            m_axis_tready     = (tmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int qb;
        s_axis_aresetn  = 1'b0;
        enable          = 1'b0;
        sync_word       = 8'b1010_0110;
        sync_word_valid = 1'b1;
        tick();
        tick();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tuser", 64'(m_axis_tuser), 64'd0);
        check("rst_s_tready", 64'(s_axis_data_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ferr", 64'(framing_error), 64'd0);
        check("rst_frames", 64'(frames_sent), 64'd0);
        s_axis_aresetn = 1'b1;
        tick();

        // Sync mapping, start latency and data pass-through.
        qb = q_data.size();
        enable = 1'b1;
        tick();
        check("start_busy", 64'(busy), 64'd1);
        check("start_tvalid0", 64'(m_axis_tvalid), 64'd0);
        enable = 1'b0;
        tick();
        check("first_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("first_tuser", 64'(m_axis_tuser), 64'd1);
        wait_beats("f1", qb + c_BEATS, 200);
        repeat (4) tick();
        check_frame("f1", qb, 8'b1010_0110);
        check("f1_frames", 64'(frames_sent), 64'd1);
        check("f1_idle_busy", 64'(busy), 64'd0);
        check("f1_idle_tvalid", 64'(m_axis_tvalid), 64'd0);

        // Random backpressure.
        tmode = 1;
        qb = q_data.size();
        start_frame();
        wait_beats("bp", qb + c_BEATS, 2000);
        repeat (6) tick();
        tmode = 0;
        repeat (4) tick();
        check("bp_count", 64'(q_data.size() - qb), 64'(c_BEATS));
        check_frame("bp", qb, 8'b1010_0110);
        check("bp_frames", 64'(frames_sent), 64'd2);

        // Snapshot isolation and back-to-back frames.
        qb = q_data.size();
        enable = 1'b1;
        wait_beats("snap_a", qb + 20, 200);
        sync_word = 8'hFF;
        wait_beats("snap_b", qb + c_BEATS + 2, 200);
        enable = 1'b0;
        wait_beats("snap_c", qb + 2 * c_BEATS, 200);
        repeat (4) tick();
        check_frame("snap1", qb, 8'b1010_0110);
        check_frame("snap2", qb + c_BEATS, 8'hFF);
        if (q_cyc.size() > qb + c_BEATS)
            check("snap_gap", 64'(q_cyc[qb+c_BEATS] - q_cyc[qb+c_BEATS-1]), 64'd1);
        check("snap_frames", 64'(frames_sent), 64'd4);
        sync_word = 8'b1010_0110;

        // Framing error on data bin 7.
        err_en = 1;
        qb = q_data.size();
        start_frame();
        wait_beats("ferr", qb + c_BEATS, 200);
        err_en = 0;
        repeat (4) tick();
        check("ferr_set", 64'(framing_error), 64'd1);
        check("ferr_count", 64'(q_data.size() - qb), 64'(c_BEATS));
        check("ferr_frames", 64'(frames_sent), 64'd5);
        repeat (10) tick();
        check("ferr_sticky", 64'(framing_error), 64'd1);

        // Reset while sync bin 5 sits in the output register.
        qb = q_data.size();
        start_frame();
        wait_beats("rmid", qb + 5, 50);
        s_axis_aresetn = 1'b0;
        tick();
        s_axis_aresetn = 1'b1;
        check("rmid_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rmid_busy", 64'(busy), 64'd0);
        check("rmid_frames", 64'(frames_sent), 64'd0);
        check("rmid_ferr", 64'(framing_error), 64'd0);
        repeat (3) tick();
        qb = q_data.size();
        start_frame();
        wait_beats("after", qb + c_BEATS, 200);
        repeat (4) tick();
        check_frame("after", qb, 8'b1010_0110);
        check("after_frames", 64'(frames_sent), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
